// File: rtl/bitonic_seq_sort.sv
// Eight-sample serial bitonic sorter: load, 24 single compare-swaps, stream out.
// Define BITONIC_ASCEND_EN for smallest-first output instead of largest-first.
module bitonic_seq_sort #(
   parameter int DATA_W = 8,
   parameter int N      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] number_in,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] number_out
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SORT,
      OUT
   } state_t;

   state_t state, state_nx;

   logic [DATA_W-1:0] r [N];
   logic [2:0] cnt;
   logic [2:0] ocnt;
   logic [4:0] step;
   logic [2:0] stage;
   logic [1:0] p;
   logic [3:0] k;
   logic [2:0] j;
   logic [2:0] lo;
   logic [2:0] hi;
   logic       accept;
   logic       dir;
   logic       desc;
   logic       swap;
   logic       sort_last;
   logic       out_last;

   assign accept    = in_valid && (state == IDLE || state == LOAD);
   assign sort_last = (state == SORT) && (step == 5'd23);
   assign out_last  = (state == OUT) && (ocnt == 3'd7);

   // step[4:2] walks the (k,j) merge stages, step[1:0] the pair within
   assign stage = step[4:2];
   assign p     = step[1:0];

   always_comb begin
      k = 4'd2;
      j = 3'd1;
      unique case (1'b1)
         (stage == 3'd0): begin k = 4'd2; j = 3'd1; end
         (stage == 3'd1): begin k = 4'd4; j = 3'd2; end
         (stage == 3'd2): begin k = 4'd4; j = 3'd1; end
         (stage == 3'd3): begin k = 4'd8; j = 3'd4; end
         (stage == 3'd4): begin k = 4'd8; j = 3'd2; end
         (stage == 3'd5): begin k = 4'd8; j = 3'd1; end
         default: begin k = 4'd2; j = 3'd1; end
      endcase
   end

   // p-th index with bit j clear, ascending; partner sets that bit
   always_comb begin
      lo = {1'b0, p};
      unique case (1'b1)
         j[0]:    lo = {p, 1'b0};
         j[1]:    lo = {p[1], 1'b0, p[0]};
         default: lo = {1'b0, p};
      endcase
   end

   assign hi  = lo | j;
   assign dir = (({1'b0, lo} & k) == 4'd0);

`ifdef BITONIC_ASCEND_EN
   assign desc = ~dir;
`else
   assign desc = dir;
`endif

   assign swap = (state == SORT) &&
                 (desc ? (r[lo] < r[hi]) : (r[lo] > r[hi]));

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = LOAD;
         LOAD: if (accept && cnt == 3'd7) state_nx = SORT;
         SORT: if (sort_last) state_nx = OUT;
         OUT:  if (out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
         ocnt  <= 3'd0;
         step  <= 5'd0;
         for (int x = 0; x < N; x++) r[x] <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            r[cnt] <= number_in;
            cnt    <= cnt + 3'd1;
         end
         if (state == SORT) begin
            step <= sort_last ? 5'd0 : step + 5'd1;
            if (swap) begin
               r[lo] <= r[hi];
               r[hi] <= r[lo];
            end
         end
         if (state == OUT) ocnt <= ocnt + 3'd1;
      end
   end

   assign busy       = (state == SORT) || (state == OUT);
   assign out_valid  = (state == OUT);
   assign number_out = out_valid ? r[ocnt] : '0;

endmodule

// File: doc/bitonic_seq_sort.md
BITONIC_SEQ_SORT -- requirements
Module: bitonic_seq_sort

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each sample in bits.
REQ-002 SHALL have parameter N, default 8, the number of samples per frame; only 8 is supported.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: number_in is offered this cycle.
REQ-006 SHALL have port number_in, input, DATA_W bits: unsigned sample.
REQ-007 SHALL have port busy, output, 1 bit: high in SORT and OUT; input is ignored while high.
REQ-008 SHALL have port out_valid, output, 1 bit: number_out is valid this cycle.
REQ-009 SHALL have port number_out, output, DATA_W bits: sorted sample, largest first by default.

Function
REQ-010 SHALL implement the FSM states IDLE, LOAD, SORT and OUT, with 8 internal DATA_W registers r[0..7].
REQ-011 In IDLE or LOAD, each in_valid cycle SHALL write number_in to r[cnt] and increment cnt; the first accept moves IDLE to LOAD; gaps in in_valid SHALL be allowed.
REQ-012 The accept with cnt==7 SHALL move to SORT on the next edge and clear cnt.
REQ-013 In SORT, the block SHALL perform exactly one compare-swap per cycle over 24 cycles, following the standard 8-input bitonic schedule.
REQ-014 The schedule SHALL use (k,j) in the order (2,1),(4,2),(4,1),(8,4),(8,2),(8,1).
REQ-015 For each (k,j), the four pairs (i, i^j) with i<(i^j) SHALL be processed in ascending order of i.
REQ-016 A pair SHALL be sorted descending (larger value to lower index) when (i&k)==0, and ascending otherwise.
REQ-017 Compare SHALL be unsigned; on equal values, the swap decision SHALL be irrelevant and both registers SHALL keep their values.
REQ-018 After the 24th compare, the FSM SHALL enter OUT; for 8 consecutive cycles it SHALL assert out_valid and drive number_out=r[0..7] in index order, then return to IDLE.
REQ-019 Latency: if the 8th sample is accepted at edge T, out_valid SHALL be high in cycles T+25..T+32, and busy SHALL be high in cycles T+1..T+32.
REQ-020 When out_valid is low, number_out SHALL be 0.
REQ-021 in_valid asserted while busy SHALL have no effect and SHALL NOT be buffered.
REQ-022 in_valid in the last OUT cycle SHALL be ignored; a new frame SHALL start at the earliest in the first IDLE cycle.
REQ-023 A fresh frame SHALL NOT depend on residual register contents from a previous frame.

Reset
REQ-024 On reset=1 at an edge, state SHALL become IDLE, cnt=0, all r[]=0, busy=0, out_valid=0 and number_out=0.
REQ-025 Reset SHALL take priority over in_valid and over any in-progress SORT or OUT.
REQ-026 A partial frame or in-flight sort SHALL be discarded by reset and SHALL produce no output.
REQ-027 The first cycle after reset is deasserted SHALL accept in_valid.

Configuration
REQ-028 Macro BITONIC_ASCEND_EN, when defined, SHALL invert the direction rule in REQ-016 so that the output is smallest first.
REQ-029 Without BITONIC_ASCEND_EN, the output SHALL be largest first.
REQ-030 Timing and the FSM SHALL be identical with and without BITONIC_ASCEND_EN.

Verification
REQ-031 Load 3,7,1,9,0,255,4,4 on consecutive cycles -> from T+25, number_out = 255,9,7,4,4,3,1,0 with out_valid high for exactly 8 cycles.
REQ-032 Same frame with in_valid toggling every other cycle -> identical output, latency measured from the 8th accept.
REQ-033 Load all 8'h5A -> output eight 8'h5A values; in_valid pulses during busy are ignored, and the next frame loaded afterward sorts correctly.
REQ-034 Assert reset on SORT cycle 10, then load 1..8 -> no output from the aborted frame; output 8,7,...,1 for the new frame.
REQ-035 With BITONIC_ASCEND_EN defined, load 200,10,30,10,0,90,60,5 -> output 0,5,10,10,30,60,90,200.
